// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular-buffer FIFO that feeds a UART serializer one word at a time.
// A word is popped only when the serializer is idle. It is presented on O_tx_data
// with a single-cycle O_txen launch pulse. The FSM then waits for the serializer's
// busy flag to rise and then fall. If busy never rises within BUSY_TIMEOUT cycles,
// the word is treated as sent.
// Ports:
//   I_clk, I_rst             clock, asynchronous active-high reset
//   I_data, I_wren           write port (one entry per cycle with I_wren high)
//   O_full, O_empty, O_count occupancy status
//   O_overflow               one-cycle pulse when a write is dropped on full
//   O_tx_data, O_txen        word and launch pulse to the serializer
//   I_tx_busy                serializer busy flag
module uart_tx_fifo #(
  parameter int unsigned DATABITS     = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                      I_clk,
  input  logic                      I_rst,
  input  logic [DATABITS-1:0]       I_data,
  input  logic                      I_wren,
  output logic                      O_full,
  output logic                      O_empty,
  output logic [$clog2(DEPTH):0]    O_count,
  output logic                      O_overflow,
  output logic [DATABITS-1:0]       O_tx_data,
  output logic                      O_txen,
  input  logic                      I_tx_busy
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned TMO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     count_q, count_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [DATABITS-1:0]  tx_data_q, tx_data_d;
  logic                 txen_q;
  logic                 ovf_q;
  logic                 pop_c;
  logic                 wr_en_c;
  logic [DATABITS-1:0]  mem_q [DEPTH];

  // Write is accepted only when not full; a pop in the same cycle does not rescue it.
  assign wr_en_c = I_wren & ~full_q;

  // Pointer update and occupancy flags for the state after this edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    count_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
               (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
  end

  // Launch FSM: next state, pop decision, timeout counter and launch data.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    pop_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && !I_tx_busy) begin
          pop_c     = 1'b1;
          tx_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (I_tx_busy) begin
          tmo_d   = '0;
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Serializer never acknowledged; give up and treat the word as sent.
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!I_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      tmo_q     <= '0;
      tx_data_q <= '0;
      txen_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      txen_q    <= pop_c;
      ovf_q     <= I_wren & full_q;
    end
  end

  // Storage array; contents are meaningless outside the pointer window, so no reset.
  always_ff @(posedge I_clk) begin
    if (wr_en_c) mem_q[wr_ptr_q[ADDR_W-1:0]] <= I_data;
  end

  assign O_full     = full_q;
  assign O_empty    = empty_q;
  assign O_count    = count_q;
  assign O_overflow = ovf_q;
  assign O_tx_data  = tx_data_q;
  assign O_txen     = txen_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DATABITS, default 8, giving the width of each byte/word.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the FIFO entries; it shall be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter BUSY_TIMEOUT, default 4, giving the maximum cycles to wait for I_tx_busy to rise after a launch.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 I_clk  in  1  system clock; all logic on the rising edge.
REQ-006 I_rst  in  1  asynchronous active-high reset.
REQ-007 I_data  in  DATABITS  write data.
REQ-008 I_wren  in  1  write strobe; one entry is written per cycle high.
REQ-009 O_full  out  1  FIFO holds DEPTH entries.
REQ-010 O_empty  out  1  FIFO holds 0 entries.
REQ-011 O_count  out  log2(DEPTH)+1  current occupancy.
REQ-012 O_overflow  out  1  one-cycle pulse when a write is dropped.
REQ-013 O_tx_data  out  DATABITS  data to the serializer I_data; held stable from launch until the word completes.
REQ-014 O_txen  out  1  one-cycle launch pulse to the serializer I_txen.
REQ-015 I_tx_busy  in  1  serializer O_busy.

Function
REQ-016 Storage SHALL be a circular buffer with write and read pointers of log2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap.
REQ-017 O_empty SHALL be high when the pointers are equal; O_full SHALL be high when the low bits are equal and the MSBs differ; O_count SHALL equal wr_ptr minus rd_ptr, modulo 2^(log2(DEPTH)+1).
REQ-018 A write with I_wren=1 and O_full=0 SHALL store I_data and increment wr_ptr at that edge.
REQ-019 A write with I_wren=1 and O_full=1 SHALL be dropped and SHALL pulse O_overflow for 1 cycle, even when a pop occurs in the same cycle.
REQ-020 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE -> LAUNCH SHALL occur when O_empty=0 and I_tx_busy=0; at that edge the head entry is loaded into O_tx_data and rd_ptr increments (pop).
REQ-022 In LAUNCH, O_txen SHALL be 1 for exactly 1 cycle, and the state SHALL go to WAIT_BUSY.
REQ-023 In WAIT_BUSY, I_tx_busy=1 SHALL move the state to WAIT_DONE; otherwise a counter SHALL run, and after BUSY_TIMEOUT cycles the state SHALL return to IDLE with the word treated as sent.
REQ-024 In WAIT_DONE, I_tx_busy=0 SHALL move the state to IDLE.
REQ-025 Latency from a write into an empty FIFO with an idle serializer to O_txen SHALL be 2 cycles (write edge, pop edge, then the LAUNCH cycle).
REQ-026 A simultaneous write and pop on a non-full FIFO SHALL both take effect, with O_count unchanged.
REQ-027 Simultaneous write and pop on an empty FIFO SHALL NOT occur, because a pop requires O_empty=0 at the same edge.
REQ-028 O_txen SHALL never pulse while I_tx_busy=1 is sampled in IDLE.
REQ-029 O_tx_data SHALL change only at the pop edge.

Reset
REQ-030 While I_rst=1, the pointers, timeout counter, O_tx_data and O_overflow SHALL be 0, and the FSM SHALL be in IDLE.
REQ-031 While I_rst=1, O_txen=0, O_empty=1, O_full=0 and O_count=0.
REQ-032 Reset asserted mid-operation (any state, any occupancy) SHALL discard all contents immediately, without waiting for a clock edge.
REQ-033 After I_rst deasserts, the first write SHALL be accepted on the first clock edge.

Verification
REQ-034 Write 0x55 into an empty FIFO with I_tx_busy=0 -> O_txen pulses 2 cycles later with O_tx_data=0x55; O_empty=1 after the pop.
REQ-035 Model the serializer so that busy rises 1 cycle after txen and lasts 10 cycles; write 0x01..0x04 back-to-back -> four O_txen pulses in order, each only after busy falls, and no overlap.
REQ-036 With I_tx_busy held 1, write DEPTH+1 words -> O_full=1 after DEPTH writes; the last write is dropped with a single O_overflow pulse; O_count=DEPTH.
REQ-037 Fill the FIFO, drain 3 entries, write 3 more -> the pointers wrap and the output order stays FIFO-correct.
REQ-038 Hold I_tx_busy=0 permanently, launch 0xA5 -> WAIT_BUSY times out after 4 cycles, returns to IDLE, and the next entry launches.
REQ-039 Assert I_rst during WAIT_DONE with 5 entries stored -> O_count=0, O_empty=1 and O_txen=0 immediately; normal operation resumes after release.
